fetch_prefetch: RTL and testbench

- Parametrised instruction-fetch stage with an in-order prefetch queue.
- Issues sequential fetch requests to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/trap): flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_prefetch_pkg.sv | 26 ++
 rtl/fetch_prefetch_if.sv | 37 +++
 rtl/fetch_prefetch_fifo.sv | 73 +++++++
 rtl/fetch_prefetch.sv | 134 +++++++++++++
 tb/tb_fetch_prefetch.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction-fetch / prefetch stage.
//   ILEN          : instruction word width.
//   XLEN_DEFAULT  : PC width used by the package-level entry type.
//   INST_NOP      : canonical no-op encoding (addi x0, x0, 0).
//   fetch_entry_t : one prefetch-queue entry, instruction word plus its PC.
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int ILEN         = 32;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [ILEN-1:0]         inst;
    logic [XLEN_DEFAULT-1:0] pc;
  } fetch_entry_t;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_prefetch_if.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_if
//   Instruction-memory bus between the fetch stage and memory.
//   Request channel : mem_req_valid / mem_req_ready / mem_req_addr.
//   Response channel: mem_rsp_valid / mem_rsp_data, in request order,
//                     no backpressure.
//   master : fetch side.   slave : memory side.
// ---------------------------------------------------------------------------
interface fetch_prefetch_if
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) ();

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [ILEN-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );

endinterface

// File: rtl/fetch_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//   Synchronous DEPTH-entry FIFO with flush. Head is read combinationally
//   from storage; a push into an empty FIFO becomes visible next cycle.
//   clk, resetn   : clock, asynchronous active-low reset.
//   flush_i       : drop all entries (wins over push/pop).
//   push_i        : write push_data_i (ignored when full).
//   pop_i         : retire the head (ignored when empty).
//   head_data_o   : current head entry.
//   count_o       : number of valid entries (0..DEPTH).
//   full_o/empty_o: occupancy flags.
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with opposite wrap bit means full.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers alone,
  // which keeps the array a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  // The caller's credit scheme must never push into a full queue.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!resetn) !(push_i && full_o)
  );

endmodule

// File: rtl/fetch_prefetch.sv
// ---------------------------------------------------------------------------
// fetch_prefetch
//   Instruction-fetch stage with an in-order prefetch queue. Issues
//   sequential word fetches while (outstanding + queued) < DEPTH, buffers
//   responses with their PCs and hands them to decode. A redirect flushes
//   the queue and discards every response still in flight.
//   clk, resetn    : clock, asynchronous active-low reset.
//   mem            : instruction-memory bus (master side).
//   redirect_valid : one-cycle redirect pulse, redirect_pc its target.
//   inst_valid/inst_ready : decode handshake.
//   inst, inst_pc, inst_pc_next : head word, its PC and PC+4 (zero when
//                    inst_valid is low).
// ---------------------------------------------------------------------------
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             resetn,
  fetch_prefetch_if.master mem,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [ILEN-1:0]  inst,
  output logic [XLEN-1:0]  inst_pc,
  output logic [XLEN-1:0]  inst_pc_next
);

  localparam int CW = count_width(DEPTH);

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // PC of the next response that will actually be kept.
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  // Holds requests off for the first cycle after reset release.
  logic            started_q;

  logic                 fifo_empty, fifo_full_unused;
  logic [$clog2(DEPTH):0] fifo_count;
  entry_t               head, push_entry;
  logic [CW:0]          in_use;
  logic                 req_valid, accept, push, pop;
  logic [XLEN-1:0]      target_pc;

  // Credit check uses registered state only, so mem_req_valid has no
  // combinational path from any input.
  assign in_use    = (CW+1)'(outstanding_q) + (CW+1)'(fifo_count);
  assign req_valid = started_q && (in_use < (CW+1)'(DEPTH)) && (drop_q == '0);

  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = fetch_pc_q;

  assign accept = req_valid && mem.mem_req_ready;
  // A response arriving with a redirect belongs to the old path: never kept.
  assign push   = mem.mem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop    = inst_valid && inst_ready;

  assign target_pc  = redirect_pc & ~XLEN'(3);
  assign push_entry = '{inst: mem.mem_rsp_data, pc: rsp_pc_q};

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;

    if (accept && !mem.mem_rsp_valid)      outstanding_d = outstanding_q + CW'(1);
    else if (!accept && mem.mem_rsp_valid) outstanding_d = outstanding_q - CW'(1);

    if (accept)                                 fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (mem.mem_rsp_valid && (drop_q != '0))    drop_d     = drop_q - CW'(1);
    if (push)                                   rsp_pc_d   = rsp_pc_q + XLEN'(4);

    // Redirect overrides: everything still in flight after this cycle,
    // including a request accepted right now, is stale.
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      drop_d     = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      started_q     <= 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_data_o (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty)
  );

  // Empty follows the asynchronously reset pointers, so the gated outputs
  // drop to zero the moment reset asserts.
  assign inst_valid   = !fifo_empty;
  assign inst         = inst_valid ? head.inst : '0;
  assign inst_pc      = inst_valid ? head.pc : '0;
  assign inst_pc_next = inst_valid ? (head.pc + XLEN'(4)) : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch
//   Drives fetch_prefetch with an in-order random-latency memory, random
//   decode backpressure and redirects, and compares every cycle against a
//   transaction-level model: a list of in-flight requests (each tagged stale
//   or live) and a list of buffered {inst, pc} words.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc, inst_pc_next;

  fetch_prefetch_if #(.XLEN(32)) bus ();

  fetch_prefetch #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_next   (inst_pc_next)
  );

  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; bit stale; }              infl_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; }        ent_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] pc_next; }     dl_t;

  infl_t       m_infl[$];
  ent_t        m_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_en;

  function automatic bit m_req_valid();
    bit any_stale = 0;
    foreach (m_infl[i]) if (m_infl[i].stale) any_stale = 1;
    return m_en && ((m_infl.size() + m_q.size()) < DEPTH) && !any_stale;
  endfunction

  // ---------------- memory + stimulus knobs ----------------
  pend_t mem_pend[$];
  int    cyc = 0, last_due = 0;
  int    ready_pct = 100, iready_pct = 100, rd_pct = 0, lat_min = 1, lat_max = 1;

  logic [31:0] acc_log[$];
  dl_t         deliv_log[$];

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dpc_at(input int i);
    return (i < deliv_log.size()) ? deliv_log[i].pc : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] dnext_at(input int i);
    return (i < deliv_log.size()) ? deliv_log[i].pc_next : 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive at posedge+1, compare at negedge, model at posedge.
  task automatic step(input bit force_rd, input logic [31:0] force_pc);
    bit          m_acc, ev;
    logic [31:0] exp_inst, exp_pc, exp_next;
    int          lat, due;

    bus.mem_req_ready = ($urandom_range(99, 0) < ready_pct);
    inst_ready        = ($urandom_range(99, 0) < iready_pct);
    redirect_valid    = force_rd || ($urandom_range(99, 0) < rd_pct);
    redirect_pc       = force_rd ? force_pc : $urandom;
    if (mem_pend.size() > 0 && mem_pend[0].due <= cyc) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = mem_pend[0].data;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = $urandom;
    end

    @(negedge clk);
    ev       = (m_q.size() > 0);
    exp_inst = ev ? m_q[0].inst : 32'h0;
    exp_pc   = ev ? m_q[0].pc : 32'h0;
    exp_next = ev ? (m_q[0].pc + 32'd4) : 32'h0;
    check("mem_req_valid", bus.mem_req_valid, m_req_valid());
    check("mem_req_addr",  bus.mem_req_addr,  m_fetch_pc);
    check("inst_valid",    inst_valid,        ev);
    check("inst",          inst,              exp_inst);
    check("inst_pc",       inst_pc,           exp_pc);
    check("inst_pc_next",  inst_pc_next,      exp_next);

    m_acc = m_req_valid() && bus.mem_req_ready;

    // Memory reacts to the DUT's real handshake.
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      acc_log.push_back(bus.mem_req_addr);
      lat = $urandom_range(lat_max, lat_min);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mem_pend.push_back('{addr: bus.mem_req_addr, data: $urandom, due: due});
    end
    if (bus.mem_rsp_valid) void'(mem_pend.pop_front());
    if (inst_valid && inst_ready) deliv_log.push_back('{pc: inst_pc, pc_next: inst_pc_next});

    @(posedge clk);
    if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
    if (bus.mem_rsp_valid) begin
      infl_t r;
      check("model response has a request", m_infl.size() > 0, 1);
      if (m_infl.size() > 0) begin
        r = m_infl.pop_front();
        if (!r.stale && !redirect_valid) m_q.push_back('{inst: bus.mem_rsp_data, pc: r.addr});
      end
    end
    if (m_acc) begin
      m_infl.push_back('{addr: m_fetch_pc, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redirect_valid) begin
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_q.delete();
      m_fetch_pc = redirect_pc & ~32'd3;
    end
    m_en = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    resetn            = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    redirect_valid    = 1'b0;
    inst_ready        = 1'b0;
    mem_pend.delete();
    m_infl.delete();
    m_q.delete();
    m_fetch_pc = RESET_PC;
    m_en       = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check("reset mem_req_valid", bus.mem_req_valid, 0);
    check("reset mem_req_addr",  bus.mem_req_addr,  RESET_PC);
    check("reset inst_valid",    inst_valid,        0);
    check("reset inst_pc",       inst_pc,           0);
    last_due = cyc;
    resetn   = 1'b1;
  endtask

  initial begin
    bit reached;

    do_reset();

    // Latency 1, always ready: sequential fetch, one instruction per cycle.
    acc_log.delete(); deliv_log.delete();
    repeat (16) step(0, '0);
    check("seq accept count",    acc_log.size(),   15);
    check("seq deliver count",   deliv_log.size(), 13);
    check("seq acc[0]",          acc_at(0),        32'h100);
    check("seq acc[1]",          acc_at(1),        32'h104);
    check("seq acc[2]",          acc_at(2),        32'h108);
    check("seq deliv[0] pc",     dpc_at(0),        32'h100);
    check("seq deliv[0] next",   dnext_at(0),      32'h104);
    check("seq deliv[12] pc",    dpc_at(12),       32'h130);

    // Redirect while a request is accepted and a response arrives together.
    step(1, 32'h0000_3000);
    check("rd1 flush inst_valid", inst_valid,        0);
    check("rd1 req held",         bus.mem_req_valid, 0);
    acc_log.delete(); deliv_log.delete();
    repeat (10) step(0, '0);
    check("rd1 first acc",        acc_at(0),         32'h3000);
    check("rd1 first deliv",      dpc_at(0),         32'h3000);

    // Decode stalled: exactly DEPTH requests, then credit exhausted.
    do_reset();
    iready_pct = 0;
    acc_log.delete(); deliv_log.delete();
    repeat (14) step(0, '0);
    check("stall accept count", acc_log.size(),    DEPTH);
    check("stall req_valid",    bus.mem_req_valid, 0);
    check("stall inst_valid",   inst_valid,        1);
    iready_pct = 100;
    acc_log.delete(); deliv_log.delete();
    repeat (4) step(0, '0);
    check("drain pop0", dpc_at(0), 32'h100);
    check("drain pop1", dpc_at(1), 32'h104);
    check("drain pop2", dpc_at(2), 32'h108);
    check("drain pop3", dpc_at(3), 32'h10C);
    check("resume acc", acc_at(0), 32'h110);

    // Latency 3, redirect with requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    acc_log.delete();
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      step(0, '0);
      if (acc_log.size() >= 2) reached = 1;
    end
    check("lat3 two in flight", reached, 1);
    step(1, 32'h0000_2002);
    check("lat3 flush inst_valid", inst_valid, 0);
    acc_log.delete(); deliv_log.delete();
    repeat (20) step(0, '0);
    check("lat3 first acc",   acc_at(0), 32'h2000);
    check("lat3 first deliv", dpc_at(0), 32'h2000);

    // Address wrap at the top of the address space.
    lat_min = 2; lat_max = 2;
    step(1, 32'hFFFF_FFFC);
    acc_log.delete(); deliv_log.delete();
    repeat (20) step(0, '0);
    check("wrap acc0",   acc_at(0),   32'hFFFF_FFFC);
    check("wrap acc1",   acc_at(1),   32'h0);
    check("wrap pc0",    dpc_at(0),   32'hFFFF_FFFC);
    check("wrap next0",  dnext_at(0), 32'h0);
    check("wrap pc1",    dpc_at(1),   32'h0);

    // Asynchronous reset with three words buffered.
    do_reset();
    lat_min = 1; lat_max = 1; iready_pct = 0;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      step(0, '0);
      if (m_q.size() == 3) reached = 1;
    end
    check("three buffered", reached, 1);
    check("pre-reset inst_valid", inst_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("async inst_valid",    inst_valid,        0);
    check("async inst",          inst,              0);
    check("async inst_pc",       inst_pc,           0);
    check("async mem_req_valid", bus.mem_req_valid, 0);
    do_reset();
    iready_pct = 100;
    acc_log.delete();
    repeat (4) step(0, '0);
    check("post-reset acc0", acc_at(0), RESET_PC);

    // Random traffic: latency, backpressure and redirects all vary.
    do_reset();
    ready_pct = 70; iready_pct = 60; rd_pct = 4; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        ready_pct  = $urandom_range(100, 30);
        iready_pct = $urandom_range(100, 20);
      end
      step(0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
